// File: rtl/keystream_engine_pkg.sv
// Shared types and helpers for the keystream engine: FSM state encoding,
// the seed zero-fix constant and the nonlinear injector function.
package keystream_pkg;

    typedef enum logic [2:0] {
        KSE_IDLE,
        KSE_WARMUP,
        KSE_RUN,
        KSE_EXHAUSTED,
        KSE_ALARM
    } kse_state_t;

    // Value written into bit 0 when an LFSR half is seeded with all zeros,
    // so the register can never lock up in the all-zero state.
    localparam logic KSE_SEED_ZERO_FIX = 1'b1;

    // Upper bounds for the injector helper; source LFSR and injector count
    // must not exceed these.
    localparam int KSE_IN_MAX  = 64;
    localparam int KSE_INJ_MAX = 64;

    // inj[k] = in[k%in_w] ^ (in[(k+1)%in_w] & in[(k+3)%in_w]) for k < inj_n.
    function automatic logic [KSE_INJ_MAX-1:0] kse_inject(
        input logic [KSE_IN_MAX-1:0] src,
        input int                    in_w,
        input int                    inj_n
    );
        logic [KSE_INJ_MAX-1:0] r;
        logic [5:0]             i0;
        logic [5:0]             i1;
        logic [5:0]             i3;
        r = '0;
        for (int k = 0; k < KSE_INJ_MAX; k++) begin
            i0 = 6'(k % in_w);
            i1 = 6'((k + 1) % in_w);
            i3 = 6'((k + 3) % in_w);
            if (k < inj_n) begin
                r[k] = src[i0] ^ (src[i1] & src[i3]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keystream_engine_if.sv
// Handshake bundle between the keystream engine and its seed source /
// keystream consumer. The master side is the environment, the slave side
// is the engine.
interface keystream_engine_if #(
    parameter int SEED_W = 96,
    parameter int OUT_W  = 8
);
    logic              flush;
    logic              seed_valid;
    logic              seed_ready;
    logic [SEED_W-1:0] seed_in;
    logic              ks_valid;
    logic              ks_ready;
    logic [OUT_W-1:0]  ks_data;
    logic              busy;
    logic              exhausted;
    logic              alarm;

    modport master (
        output flush, seed_valid, seed_in, ks_ready,
        input  seed_ready, ks_valid, ks_data, busy, exhausted, alarm
    );

    modport slave (
        input  flush, seed_valid, seed_in, ks_ready,
        output seed_ready, ks_valid, ks_data, busy, exhausted, alarm
    );
endinterface

// File: rtl/keystream_engine_lfsr.sv
// kse_lfsr: Fibonacci-style left-shifting LFSR with synchronous clear,
// seed load (all-zero seed replaced by the zero-fix pattern) and an
// injection mask XORed into evenly spaced stages on every step.
module kse_lfsr
    import keystream_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = '1,
    parameter int               INJ_N = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [INJ_N-1:0] inj_i,
    output logic [WIDTH-1:0] state_o
);
    localparam int SPACING = WIDTH / INJ_N;

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] inj_mask;
    logic [WIDTH-1:0] seed_fix;

    // Injector k lands on stage k*SPACING; all other stages get no injection.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inj
        if ((gi % SPACING == 0) && (gi / SPACING < INJ_N)) begin : g_tap
            assign inj_mask[gi] = inj_i[gi / SPACING];
        end else begin : g_none
            assign inj_mask[gi] = 1'b0;
        end
    end

    assign seed_fix = (seed_i == '0) ? {{(WIDTH-1){1'b0}}, KSE_SEED_ZERO_FIX} : seed_i;
    assign state_o  = state_q;

    // Next state: clear beats load beats step.
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = '0;
        end else if (load_i) begin
            state_d = seed_fix;
        end else if (step_i) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)} ^ inj_mask;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end
endmodule

// File: rtl/keystream_engine.sv
// keystream_engine: source LFSR drives a nonlinear injector into a wide
// output LFSR; keystream words are its low OUT_W bits. Handles seeding,
// warm-up, valid/ready backpressure and a per-seed word limit.
// Optional repeat-word health monitor: define KSE_HEALTH_MON_EN.
module keystream_engine
    import keystream_pkg::*;
#(
    parameter int                    IN_W       = 32,
    parameter int                    OUT_LFSR_W = 64,
    parameter int                    OUT_W      = 8,
    parameter logic [IN_W-1:0]       TAPS_IN    = 32'h80200003,
    parameter logic [OUT_LFSR_W-1:0] TAPS_OUT   = 64'hD800000000000000,
    parameter int                    INJ_N      = 16,
    parameter int                    WARMUP     = 128,
    parameter int                    MAX_WORDS  = 0,
    parameter int                    REP_LIMIT  = 4
) (
    input  logic               clk,
    input  logic               reset,
    keystream_engine_if.slave  bus
);
    localparam int              WU_W       = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WU_W-1:0] WU_LAST    = WU_W'(WARMUP - 1);
    localparam logic [31:0]     WORDS_LAST = 32'(MAX_WORDS - 1);

    kse_state_t              state_q, state_d;
    logic [WU_W-1:0]         wu_q, wu_d;
    logic [31:0]             words_q, words_d;
    logic                    seed_fire, ks_fire, lfsr_load, lfsr_step, alarm_hit;
    logic [IN_W-1:0]         in_state;
    logic [OUT_LFSR_W-1:0]   out_state;
    logic [INJ_N-1:0]        inj;

    assign bus.seed_ready = (state_q == KSE_IDLE) || (state_q == KSE_EXHAUSTED);
    assign bus.ks_valid   = (state_q == KSE_RUN);
    assign bus.busy       = (state_q == KSE_WARMUP) || (state_q == KSE_RUN);
    assign bus.exhausted  = (state_q == KSE_EXHAUSTED);
    assign bus.ks_data    = out_state[OUT_W-1:0];

    assign seed_fire = bus.seed_valid & bus.seed_ready;
    assign ks_fire   = bus.ks_valid & bus.ks_ready;
    // flush wins: a word consumed in the flush cycle does not step the LFSRs.
    assign lfsr_load = seed_fire & ~bus.flush;
    assign lfsr_step = ~bus.flush & ((state_q == KSE_WARMUP) | ks_fire);

    // Injectors are computed from the pre-step source LFSR.
    assign inj = INJ_N'(kse_inject(KSE_IN_MAX'(in_state), IN_W, INJ_N));

    kse_lfsr #(.WIDTH(IN_W), .TAPS(TAPS_IN), .INJ_N(1)) u_lfsr_in (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (bus.flush),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .seed_i  (bus.seed_in[IN_W-1:0]),
        .inj_i   (1'b0),
        .state_o (in_state)
    );

    kse_lfsr #(.WIDTH(OUT_LFSR_W), .TAPS(TAPS_OUT), .INJ_N(INJ_N)) u_lfsr_out (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (bus.flush),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .seed_i  (bus.seed_in[IN_W +: OUT_LFSR_W]),
        .inj_i   (inj),
        .state_o (out_state)
    );

`ifdef KSE_HEALTH_MON_EN
    localparam int RC_W = $clog2(REP_LIMIT + 1);

    logic [OUT_W-1:0] prev_q;
    logic [RC_W-1:0]  rep_q, rep_d;

    // Run length of identical fired words; zero means no previous word yet.
    always_comb begin
        rep_d     = rep_q;
        alarm_hit = 1'b0;
        if (ks_fire) begin
            if ((rep_q != '0) && (bus.ks_data == prev_q)) begin
                rep_d = rep_q + 1'b1;
            end else begin
                rep_d = RC_W'(1);
            end
            alarm_hit = (rep_d >= RC_W'(REP_LIMIT));
        end
    end

    // Remember the last fired word; forget history on flush or reseed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_q  <= '0;
            prev_q <= '0;
        end else if (bus.flush || lfsr_load) begin
            rep_q  <= '0;
            prev_q <= '0;
        end else if (ks_fire) begin
            rep_q  <= rep_d;
            prev_q <= bus.ks_data;
        end
    end

    assign bus.alarm = (state_q == KSE_ALARM);
`else
    assign alarm_hit = 1'b0;
    assign bus.alarm = 1'b0;
`endif

    // Next-state logic for the control FSM and its counters.
    always_comb begin
        state_d = state_q;
        wu_d    = wu_q;
        words_d = words_q;
        if (bus.flush) begin
            state_d = KSE_IDLE;
            wu_d    = '0;
            words_d = '0;
        end else begin
            case (state_q)
                KSE_IDLE, KSE_EXHAUSTED: begin
                    if (seed_fire) begin
                        state_d = KSE_WARMUP;
                        wu_d    = '0;
                        words_d = '0;
                    end
                end
                KSE_WARMUP: begin
                    if (wu_q == WU_LAST) begin
                        state_d = KSE_RUN;
                        wu_d    = '0;
                    end else begin
                        wu_d = wu_q + 1'b1;
                    end
                end
                KSE_RUN: begin
                    if (ks_fire) begin
                        words_d = words_q + 32'd1;
                        if (alarm_hit) begin
                            state_d = KSE_ALARM;
                        end else if ((MAX_WORDS != 0) && (words_q == WORDS_LAST)) begin
                            state_d = KSE_EXHAUSTED;
                        end
                    end
                end
                KSE_ALARM: state_d = KSE_ALARM;
                default:   state_d = KSE_IDLE;
            endcase
        end
    end

    // FSM and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= KSE_IDLE;
            wu_q    <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            wu_q    <= wu_d;
            words_q <= words_d;
        end
    end
endmodule
